// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round-constant fetch path:
// default table length, the 64 K constants and the reader state type.
package sha256_pkg;

  localparam int K_LENGTH_DEFAULT = 64;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } k_state_e;

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 K constant lookup; used by k_rom_reader only when
// K_ROM_INTERNAL_EN is defined.
module sha256_k_rom
  import sha256_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);

  assign data = K_TABLE[addr];

endmodule

// File: rtl/k_rom_reader.sv
// Round-constant fetch initiator: walks the K table from 0 to K_LENGTH-1,
// one read at a time, and hands each word to the round datapath over a
// valid/ready handshake. Build option K_ROM_INTERNAL_EN replaces the external
// memory with an internal constant ROM (latency forced to 1, no read strobes).
module k_rom_reader
  import sha256_pkg::*;
#(
  parameter int K_LENGTH    = K_LENGTH_DEFAULT,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        round_ready,
  input  logic [31:0]                 k_data,
  output logic                        k_read_en,
  output logic [$clog2(K_LENGTH)-1:0] k_address,
  output logic                        k_valid,
  output logic [31:0]                 k_value,
  output logic [$clog2(K_LENGTH)-1:0] k_index,
  output logic                        address_read_complete
);

  localparam int AW     = $clog2(K_LENGTH);
  localparam int DATA_W = 32;
`ifdef K_ROM_INTERNAL_EN
  localparam int   EFF_LAT     = 1;
  localparam logic READ_STROBE = 1'b0;
`else
  localparam int   EFF_LAT     = MEM_LATENCY;
  localparam logic READ_STROBE = 1'b1;
`endif
  localparam logic [2:0]    WAIT_INIT = 3'(EFF_LAT - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(K_LENGTH - 1);

  k_state_e          state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              k_read_en_q, k_read_en_d;
  logic [AW-1:0]     k_address_q, k_address_d;
  logic              k_valid_q, k_valid_d;
  logic [DATA_W-1:0] k_value_q, k_value_d;
  logic [AW-1:0]     k_index_q, k_index_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] word_in;

`ifdef K_ROM_INTERNAL_EN
  sha256_k_rom #(.AW(AW)) u_rom (
    .addr (idx_q),
    .data (word_in)
  );
  logic unused_k_data;
  assign unused_k_data = ^k_data;
`else
  assign word_in = k_data;
`endif

  // Next-state logic: abort on enable low, otherwise step the fetch sequence.
  // The read strobe is registered, so it is raised on the transition into REQ.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    k_read_en_d = 1'b0;
    k_address_d = k_address_q;
    k_valid_d   = k_valid_q;
    k_value_d   = k_value_q;
    k_index_d   = k_index_q;
    done_d      = done_q;
    if (!enable) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      wcnt_d      = '0;
      k_address_d = '0;
      k_valid_d   = 1'b0;
      k_value_d   = '0;
      k_index_d   = '0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_REQ;
          k_read_en_d = READ_STROBE;
          k_address_d = idx_q;
        end
        ST_REQ: begin
          state_d = ST_WAIT;
          wcnt_d  = WAIT_INIT;
        end
        ST_WAIT: begin
          if (wcnt_q == '0) begin
            k_value_d = word_in;
            k_index_d = idx_q;
            k_valid_d = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            wcnt_d = wcnt_q - 3'd1;
          end
        end
        ST_HOLD: begin
          if (k_valid_q && round_ready) begin
            k_valid_d = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d       = idx_q + 1'b1;
              state_d     = ST_REQ;
              k_read_en_d = READ_STROBE;
              k_address_d = idx_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset clears everything, including the data word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      k_read_en_q <= 1'b0;
      k_address_q <= '0;
      k_valid_q   <= 1'b0;
      k_value_q   <= '0;
      k_index_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      k_read_en_q <= k_read_en_d;
      k_address_q <= k_address_d;
      k_valid_q   <= k_valid_d;
      k_value_q   <= k_value_d;
      k_index_q   <= k_index_d;
      done_q      <= done_d;
    end
  end

  assign k_read_en             = k_read_en_q;
  assign k_address             = k_address_q;
  assign k_valid               = k_valid_q;
  assign k_value               = k_value_q;
  assign k_index               = k_index_q;
  assign address_read_complete = done_q;

endmodule

// File: tb/tb_k_rom_reader.sv
// Bench for k_rom_reader: two instances (memory latency 1 and 3), each with a
// behavioural SRAM that returns valid data only on the one cycle the reader
// must sample it and junk on every other cycle.
module tb_k_rom_reader;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] JUNK = 32'h0badf00d;
`ifdef K_ROM_INTERNAL_EN
  localparam int LAT1 = 1;
  localparam int LAT3 = 1;
  localparam int EXP_PULSE = 0;
`else
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  localparam int EXP_PULSE = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en, rdy;
  logic [31:0] kd1, kd3, kv1, kv3;
  logic [5:0]  ka1, ka3, ki1, ki3;
  logic        rd1, rd3, v1, v3, c1, c3;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  k_rom_reader #(.K_LENGTH(64), .MEM_LATENCY(1)) dut1 (
    .clock(clk), .reset(rst), .enable(en[0]), .round_ready(rdy[0]), .k_data(kd1),
    .k_read_en(rd1), .k_address(ka1), .k_valid(v1), .k_value(kv1), .k_index(ki1),
    .address_read_complete(c1)
  );

  k_rom_reader #(.K_LENGTH(64), .MEM_LATENCY(3)) dut3 (
    .clock(clk), .reset(rst), .enable(en[1]), .round_ready(rdy[1]), .k_data(kd3),
    .k_read_en(rd3), .k_address(ka3), .k_valid(v3), .k_value(kv3), .k_index(ki3),
    .address_read_complete(c3)
  );

  // SRAM models: a read seen at an edge yields K[addr] only in the cycle that
  // ends exactly L cycles after the strobe cycle.
  logic [5:0] pa1 = '0, pa3 = '0;
  int         pc1 = 0, pc3 = 0;
  always @(posedge clk) begin
    if (rd1) begin pa1 <= ka1; pc1 <= 1; end
    else if (pc1 > 0) pc1 <= pc1 - 1;
    if (rd3) begin pa3 <= ka3; pc3 <= 3; end
    else if (pc3 > 0) pc3 <= pc3 - 1;
  end
`ifdef K_ROM_INTERNAL_EN
  assign kd1 = 32'hdeadbeef;
  assign kd3 = 32'hdeadbeef;
`else
  assign kd1 = (pc1 == 1) ? KT[pa1] : JUNK;
  assign kd3 = (pc3 == 1) ? KT[pa3] : JUNK;
`endif

  function automatic logic        f_rd(int s);    return (s == 1) ? rd3 : rd1; endfunction
  function automatic logic [5:0]  f_addr(int s);  return (s == 1) ? ka3 : ka1; endfunction
  function automatic logic        f_valid(int s); return (s == 1) ? v3  : v1;  endfunction
  function automatic logic [31:0] f_value(int s); return (s == 1) ? kv3 : kv1; endfunction
  function automatic logic [5:0]  f_index(int s); return (s == 1) ? ki3 : ki1; endfunction
  function automatic logic        f_done(int s);  return (s == 1) ? c3  : c1;  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int s, input string tag);
    chk({tag, " rd"},    64'(f_rd(s)),    64'd0);
    chk({tag, " addr"},  64'(f_addr(s)),  64'd0);
    chk({tag, " valid"}, 64'(f_valid(s)), 64'd0);
    chk({tag, " value"}, 64'(f_value(s)), 64'd0);
    chk({tag, " index"}, 64'(f_index(s)), 64'd0);
    chk({tag, " done"},  64'(f_done(s)),  64'd0);
  endtask

  // Wait for word i, check its latency, strobe and contents, then hold off
  // the handshake for 'hold' cycles while checking the word stays put.
  task automatic fetch_word(input int s, input int lat, input int i, input int hold);
    int n;
    int pulses;
    n = 0;
    pulses = 0;
    do begin
      step();
      n++;
      if (f_rd(s)) begin
        pulses++;
        chk($sformatf("addr s%0d i%0d", s, i), 64'(f_addr(s)), 64'(i));
      end
      if (!f_valid(s)) rdy[s] = 1'($urandom_range(0, 1));
    end while (!f_valid(s) && n < 40);
    chk($sformatf("valid s%0d i%0d", s, i), 64'(f_valid(s)), 64'd1);
    chk($sformatf("latency s%0d i%0d", s, i), 64'(n), 64'(lat + 2));
    chk($sformatf("pulses s%0d i%0d", s, i), 64'(pulses), 64'(EXP_PULSE));
    chk($sformatf("value s%0d i%0d", s, i), 64'(f_value(s)), 64'(KT[i]));
    chk($sformatf("index s%0d i%0d", s, i), 64'(f_index(s)), 64'(i));
    rdy[s] = (hold > 0) ? 1'b0 : 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      chk($sformatf("hold valid s%0d i%0d", s, i), 64'(f_valid(s)), 64'd1);
      chk($sformatf("hold value s%0d i%0d", s, i), 64'(f_value(s)), 64'(KT[i]));
      chk($sformatf("hold rd s%0d i%0d", s, i), 64'(f_rd(s)), 64'd0);
    end
    rdy[s] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 2'b00;
    rdy = 2'b00;
    repeat (3) step();
    chk_idle(0, "reset s0");
    chk_idle(1, "reset s1");
    rst = 1'b0;
    step();

    // Full pass, latency 1, with a 5-cycle stall at index 10.
    en[0] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      fetch_word(0, LAT1, i, (i == 10) ? 5 : 0);
      if (i == 10) chk("k10 value", 64'(kv1), 64'h243185be);
    end
    chk("last value", 64'(kv1), 64'hc67178f2);
    step();
    chk("complete", 64'(c1), 64'd1);
    chk("valid after last", 64'(v1), 64'd0);
    for (int h = 0; h < 10; h++) begin
      rdy[0] = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("done hold %0d", h), 64'(c1), 64'd1);
      chk($sformatf("done rd %0d", h), 64'(rd1), 64'd0);
      chk($sformatf("done valid %0d", h), 64'(v1), 64'd0);
    end
    en[0] = 1'b0;
    step();
    chk_idle(0, "disable after done");

    // Latency 3 with random backpressure, abort during WAIT at index 20.
    en[1] = 1'b1;
    for (int i = 0; i < 20; i++) fetch_word(1, LAT3, i, int'($urandom_range(0, 3)));
    step();
    chk("req20 rd", 64'(rd3), 64'(EXP_PULSE));
    chk("req20 valid", 64'(v3), 64'd0);
    step();
    en[1] = 1'b0;
    step();
    chk_idle(1, "abort");
    step();
    chk_idle(1, "abort idle");
    en[1] = 1'b1;
    for (int i = 0; i < 6; i++) fetch_word(1, LAT3, i, int'($urandom_range(0, 2)));
    en[1] = 1'b0;
    step();
    chk_idle(1, "disable s1");

    // Reset mid-pass on the latency-1 instance, then restart from address 0.
    en[0] = 1'b1;
    for (int i = 0; i < 3; i++) fetch_word(0, LAT1, i, 0);
    step();
    rst = 1'b1;
    step();
    chk_idle(0, "midpass reset");
    rst = 1'b0;
    fetch_word(0, LAT1, 0, 0);
    fetch_word(0, LAT1, 1, 0);
    en[0] = 1'b0;
    step();
    chk_idle(0, "final disable");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/k_rom_reader.md
Name: k_rom_reader

Overview:
- Initiator side of the round-constant fetch interface. Walks the K table in order from address 0 to K_LENGTH-1.
- Issues one memory read at a time and waits a fixed memory latency.
- Presents each fetched word to the round-constant consumer with a valid/ready handshake.
- Raises address_read_complete after the last word is consumed. Sits between the K-constant SRAM and the compression round datapath.

Parameters:
- K_LENGTH, 64, number of round constants; address width is $clog2(K_LENGTH).
- MEM_LATENCY, 1, cycles from read-enable sample to valid k_data; legal range 1..7.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  high = run a fetch pass; low = abort and return to idle
- round_ready  input  1  consumer accepts k_value this cycle
- k_data  input  32  memory read data
- k_read_en  output  1  one-cycle read strobe to memory
- k_address  output  $clog2(K_LENGTH)  memory address
- k_valid  output  1  k_value holds a fetched word
- k_value  output  32  current round constant
- k_index  output  $clog2(K_LENGTH)  index of the word in k_value
- address_read_complete  output  1  all K_LENGTH words consumed

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. State after reset is IDLE, with the index counter and wait counter at 0.
- States: IDLE, REQ, WAIT, HOLD, DONE.
- IDLE -> REQ when enable=1.
- REQ: for one cycle, k_read_en=1 and k_address=idx. Then go to WAIT with wcnt=MEM_LATENCY-1.
- WAIT:
  - if wcnt=0, capture k_data into k_value, set k_index=idx and k_valid=1 (all visible next cycle), and go to HOLD;
  - otherwise decrement wcnt.
  - k_data is sampled exactly MEM_LATENCY cycles after the k_read_en cycle.
- HOLD: k_value, k_index and k_valid are stable until round_ready=1. On the handshake (k_valid & round_ready):
  - k_valid clears next cycle;
  - if idx=K_LENGTH-1, go to DONE and set address_read_complete=1;
  - otherwise idx+1 and go to REQ.
- Timing:
  - first k_valid appears MEM_LATENCY+2 cycles after enable is first sampled high in IDLE;
  - steady-state throughput is one word per MEM_LATENCY+2 cycles when round_ready is held high.
- DONE: address_read_complete is held at 1 and k_valid=0 until enable=0, then go to IDLE. No restart while enable stays high.
- enable=0 in any state: next cycle state=IDLE, idx=0, and k_valid, k_read_en and address_read_complete are 0. k_value is cleared to 0. An in-flight read is discarded.
- reset=1 overrides enable. Reset mid-pass behaves identically to enable=0.
- Index counter does not wrap: idx never exceeds K_LENGTH-1. round_ready is ignored when k_valid=0.
- k_address holds its last value outside REQ. It is meaningful only while k_read_en=1.

Optional Feature:
- Macro K_ROM_INTERNAL_EN.
- Defined:
  - k_data is ignored; the word comes from an internal combinational constant ROM indexed by idx;
  - MEM_LATENCY is treated as 1;
  - k_read_en stays 0;
  - the handshake and all timing otherwise unchanged.
- Undefined: external memory path exactly as above.

Decomposition:
- Package sha256_pkg:
  - K_LENGTH default;
  - the 64 SHA-256 K constants as a localparam array;
  - the state enumeration for this block.
- One natural sub-module, sha256_k_rom (address in, 32-bit constant out, combinational from the package array). It is instantiated only under K_ROM_INTERNAL_EN.

Test Plan:
- Reset, then enable=1 and round_ready=1, memory model returning SHA-256 K, MEM_LATENCY=1:
  - k_read_en pulses at address 0;
  - k_valid with k_value=0x428a2f98 and k_index=0 appears 3 cycles after enable;
  - 64 words in order, last k_value=0xc67178f2;
  - address_read_complete=1 after that handshake.
- Backpressure: round_ready held 0 for 5 cycles at index 10 -> k_value=0x243185be stays stable with k_valid=1; no new k_read_en until the handshake.
- MEM_LATENCY=3 -> k_data is sampled exactly 3 cycles after each k_read_en; a wrong-data value driven on other cycles never appears in k_value.
- enable dropped at index 20 during WAIT -> next cycle all outputs 0 and state IDLE. Re-enable restarts at address 0.
- Hold enable=1 after DONE for 10 cycles -> address_read_complete stays 1 and no reads occur. enable=0 clears it next cycle.
- K_ROM_INTERNAL_EN defined, k_data tied to 0xdeadbeef -> same 64-word sequence as the first test, and k_read_en never asserts.
